wm_panel_ctrl: RTL and testbench
================================

WM_PANEL_CTRL -- requirements
Module: wm_panel_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable synchronised cycles required to accept a button level change.
REQ-002 Parameter ACK_CYCLES, default 8: maximum cycles allowed for done to fall after start is issued.
REQ-003 clk  input  1  Single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 btn_start  input  1  Raw start button; asynchronous and bouncing; active-high.
REQ-006 btn_double  input  1  Raw double-wash toggle button.
REQ-007 btn_dry  input  1  Raw dry/steam toggle button.
REQ-008 btn_pause  input  1  Raw pause toggle button.
REQ-009 done  input  1  Washer availability; high = washer idle.
REQ-010 start  output  1  One-cycle start pulse to the washer.
REQ-011 double_wash  output  1  Latched double-wash selection.
REQ-012 dry_wash  output  1  Latched dry/steam selection.
REQ-013 time_pause  output  1  Pause request level.
REQ-014 busy  output  1  High in every state except SELECT.
REQ-015 fault  output  1  Sticky acknowledge-timeout flag.

Function
REQ-016 Each button SHALL pass through a 2-flop synchroniser and then a per-button debouncer; the debounced level SHALL change only after the synchronised input differs from it for DB_CYCLES consecutive cycles, and any mismatch-free cycle SHALL clear that counter.
REQ-017 A "press" SHALL be a single-cycle pulse on a 0->1 transition of a debounced level; total latency from a clean raw edge to the press is DB_CYCLES+2 or DB_CYCLES+3 cycles, depending on synchroniser phase.
REQ-018 FSM states: SELECT, ARM, WAIT_ACK, RUN.
REQ-019 SELECT: a double press SHALL toggle double_wash; a dry press SHALL toggle dry_wash; a pause press SHALL be ignored; a start press with done=1 SHALL move to ARM and clear fault; a start press with done=0 SHALL be ignored.
REQ-020 ARM: start=1 for exactly this one cycle; next state WAIT_ACK with the ack counter cleared.
REQ-021 WAIT_ACK: done=0 SHALL move to RUN; after ACK_CYCLES cycles with done=1, fault SHALL be set and the FSM SHALL return to SELECT.
REQ-022 RUN: a pause press SHALL toggle time_pause; double and dry presses SHALL be ignored, so options stay frozen; done=1 SHALL clear time_pause and return to SELECT in the same cycle.
REQ-023 Simultaneous presses in SELECT: a start press SHALL take priority, and option toggles in that same cycle SHALL be discarded.
REQ-024 In RUN, a pause press in the same cycle as done=1 SHALL be discarded, and time_pause SHALL end at 0.
REQ-025 start SHALL never be high for two consecutive cycles; ack and debounce counters SHALL saturate and never wrap.
REQ-026 Unreachable FSM encodings SHALL return to SELECT with all outputs at their reset values.

Reset
REQ-027 rst_n low SHALL asynchronously force state to SELECT, clear all synchronisers, debounced levels and counters, and drive start=0, double_wash=0, dry_wash=0, time_pause=0, busy=0 and fault=0.
REQ-028 Reset asserted mid-RUN SHALL abandon the cycle; after release, no start pulse SHALL be issued until a new, fully debounced press arrives.

Configuration
REQ-029 Macro WM_PANEL_AUTO_CLEAR_EN defined: the RUN->SELECT transition SHALL also clear double_wash and dry_wash.
REQ-030 Macro WM_PANEL_AUTO_CLEAR_EN undefined: selections SHALL be retained across cycles until toggled or reset.

Verification
REQ-031 btn_double bounces 5 times with 3-cycle glitches, then stays high 20 cycles (DB_CYCLES=16) -> exactly one toggle; double_wash goes 0->1.
REQ-032 Option dry_wash=1, then start press with done=1 -> start high exactly 1 cycle; done falls 3 cycles later -> busy=1, state RUN; dry press during RUN -> dry_wash stays 1.
REQ-033 In RUN: pause press -> time_pause=1; second press -> time_pause=0; third press, then done=1 -> time_pause=0 and busy=0 next cycle.
REQ-034 Start press with done held at 1 -> after 8 cycles fault=1 and busy=0; next start press with done=1 -> fault=0.
REQ-035 Start and double pressed in the same cycle -> start pulse issued and double_wash unchanged; rst_n pulled low mid-RUN -> all outputs 0 immediately.
REQ-036 Cycle completes with double_wash=1 -> double_wash=0 with WM_PANEL_AUTO_CLEAR_EN defined; double_wash=1 with it undefined.

Source files
------------

// File: rtl/wm_panel_ctrl.sv
// wm_panel_ctrl: washing-machine front-panel controller.
// Four raw buttons are synchronised and debounced into single-cycle presses.
// A four-state FSM latches option selections, issues a one-cycle start pulse
// and supervises the washer's done acknowledge.
// Optional build macro WM_PANEL_AUTO_CLEAR_EN: when defined, finishing a wash
// cycle (RUN -> SELECT) also clears double_wash and dry_wash.
module wm_panel_ctrl #(
  parameter int DB_CYCLES  = 16,
  parameter int ACK_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start,
  input  logic btn_double,
  input  logic btn_dry,
  input  logic btn_pause,
  input  logic done,
  output logic start,
  output logic double_wash,
  output logic dry_wash,
  output logic time_pause,
  output logic busy,
  output logic fault
);

  localparam int NB  = 4;
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int AW  = $clog2(ACK_CYCLES + 1);

  // Button index order: 0 start, 1 double, 2 dry, 3 pause
  logic [NB-1:0] raw;
  logic [NB-1:0] press;

  assign raw = {btn_pause, btn_dry, btn_double, btn_start};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic           s1_reg;
      logic           s2_reg;
      logic           lvl_reg;
      logic           prs_reg;
      logic [DBW-1:0] cnt_reg;

      // Synchronise, debounce, and pulse on a debounced 0->1 transition
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          lvl_reg <= 1'b0;
          prs_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg  <= raw[gi];
          s2_reg  <= s1_reg;
          prs_reg <= 1'b0;
          if (s2_reg != lvl_reg) begin
            // Counter stops at DB_CYCLES-1 and the level flips on the
            // DB_CYCLES-th consecutive mismatching cycle, so it never wraps.
            if (cnt_reg >= DBW'(DB_CYCLES - 1)) begin
              lvl_reg <= s2_reg;
              prs_reg <= s2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign press[gi] = prs_reg;
    end
  endgenerate

  // Three-bit encoding leaves spare codes that the default branch recovers from
  typedef enum logic [2:0] {
    SELECT   = 3'd0,
    ARM      = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] ack_reg;
  logic          start_reg;
  logic          double_reg;
  logic          dry_reg;
  logic          pause_reg;
  logic          busy_reg;
  logic          fault_reg;

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= SELECT;
      ack_reg    <= '0;
      start_reg  <= 1'b0;
      double_reg <= 1'b0;
      dry_reg    <= 1'b0;
      pause_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        SELECT: begin
          if (press[0] && done) begin
            // Accepted start wins; option toggles this cycle are dropped
            state_reg <= ARM;
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
            fault_reg <= 1'b0;
          end else begin
            if (press[1]) double_reg <= ~double_reg;
            if (press[2]) dry_reg    <= ~dry_reg;
          end
        end
        ARM: begin
          state_reg <= WAIT_ACK;
          ack_reg   <= '0;
        end
        WAIT_ACK: begin
          if (!done) begin
            state_reg <= RUN;
          end else if (ack_reg >= AW'(ACK_CYCLES - 1)) begin
            state_reg <= SELECT;
            busy_reg  <= 1'b0;
            fault_reg <= 1'b1;
          end else begin
            ack_reg <= ack_reg + 1'b1;
          end
        end
        RUN: begin
          if (done) begin
            // Completion overrides a coincident pause press
            state_reg <= SELECT;
            busy_reg  <= 1'b0;
            pause_reg <= 1'b0;
`ifdef WM_PANEL_AUTO_CLEAR_EN
            double_reg <= 1'b0;
            dry_reg    <= 1'b0;
`endif
          end else if (press[3]) begin
            pause_reg <= ~pause_reg;
          end
        end
        default: begin
          state_reg  <= SELECT;
          ack_reg    <= '0;
          start_reg  <= 1'b0;
          double_reg <= 1'b0;
          dry_reg    <= 1'b0;
          pause_reg  <= 1'b0;
          busy_reg   <= 1'b0;
          fault_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign start       = start_reg;
  assign double_wash = double_reg;
  assign dry_wash    = dry_reg;
  assign time_pause  = pause_reg;
  assign busy        = busy_reg;
  assign fault       = fault_reg;

endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Directed bench for wm_panel_ctrl: a table of press/expect records plus
// hand-written sequences for bounce, ack timeout, run/pause and reset cases.
module tb_wm_panel_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_start = 1'b0;
  logic btn_double = 1'b0;
  logic btn_dry = 1'b0;
  logic btn_pause = 1'b0;
  logic done = 1'b1;
  logic start, double_wash, dry_wash, time_pause, busy, fault;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int consec_cnt = 0;
  logic prev_start = 1'b0;

  wm_panel_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_double(btn_double),
    .btn_dry(btn_dry), .btn_pause(btn_pause), .done(done),
    .start(start), .double_wash(double_wash), .dry_wash(dry_wash),
    .time_pause(time_pause), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // Count start pulses and back-to-back start cycles
  always @(negedge clk) begin
    prev_start <= start;
    if (start === 1'b1) start_cnt <= start_cnt + 1;
    if (start === 1'b1 && prev_start === 1'b1) consec_cnt <= consec_cnt + 1;
  end

  typedef struct {
    string      name;
    logic [3:0] btn;      // {pause, dry, double, start}
    logic       dn;
    logic       exp_dw;
    logic       exp_dry;
    logic       exp_busy;
    logic       exp_fault;
    int         exp_starts;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic set_btn(logic [3:0] m);
    btn_start  = m[0];
    btn_double = m[1];
    btn_dry    = m[2];
    btn_pause  = m[3];
  endtask

  // Hold buttons long enough to debounce, then release and let it settle
  task automatic press_apply(logic [3:0] m, logic dn);
    done = dn;
    set_btn(m);
    repeat (22) tick();
    set_btn(4'b0000);
    repeat (22) tick();
  endtask

  task automatic do_reset();
    set_btn(4'b0000);
    done = 1'b1;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (start === 1'b1) seen = 1'b1;
    end
  endtask

  // Press start with done=1, drop done shortly after the pulse, end in RUN
  task automatic run_start(string tag);
    bit seen;
    btn_start = 1'b1;
    done = 1'b1;
    wait_start(seen);
    chk({tag, "_start_seen"}, int'(seen), 1);
    tick();
    chk({tag, "_start_one_cycle"}, int'(start), 0);
    tick();
    done = 1'b0;
    btn_start = 1'b0;
    repeat (20) tick();
    chk({tag, "_run_busy"}, int'(busy), 1);
    chk({tag, "_run_fault"}, int'(fault), 0);
  endtask

  initial begin
    bit seen;
    int sc;
    int exp_dw_end;

    vecs[0] = '{"dbl_on",      4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{"dry_on",      4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[2] = '{"dbl_off",     4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{"pause_sel",   4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[4] = '{"start_nodn",  4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{"start_tmo",   4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[6] = '{"start_dbl",   4'b0011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[7] = '{"dbl_sticky",  4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};

    // Reset state
    repeat (3) tick();
    chk("rst_start", int'(start), 0);
    chk("rst_double", int'(double_wash), 0);
    chk("rst_dry", int'(dry_wash), 0);
    chk("rst_pause", int'(time_pause), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
    rst_n = 1'b1;
    tick();

    // Table-driven presses
    for (int i = 0; i < 8; i++) begin
      sc = start_cnt;
      press_apply(vecs[i].btn, vecs[i].dn);
      $display("row %0d %s: dw=%0b dry=%0b busy=%0b fault=%0b starts=%0d",
               i, vecs[i].name, double_wash, dry_wash, busy, fault, start_cnt - sc);
      chk({vecs[i].name, "_dw"}, int'(double_wash), int'(vecs[i].exp_dw));
      chk({vecs[i].name, "_dry"}, int'(dry_wash), int'(vecs[i].exp_dry));
      chk({vecs[i].name, "_busy"}, int'(busy), int'(vecs[i].exp_busy));
      chk({vecs[i].name, "_fault"}, int'(fault), int'(vecs[i].exp_fault));
      chk({vecs[i].name, "_starts"}, start_cnt - sc, vecs[i].exp_starts);
    end

    // Bouncing double button: exactly one toggle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      btn_double = 1'b1;
      repeat (3) tick();
      btn_double = 1'b0;
      repeat (3) tick();
    end
    chk("bounce_glitch_ignored", int'(double_wash), 0);
    btn_double = 1'b1;
    repeat (20) tick();
    chk("bounce_toggle", int'(double_wash), 1);
    btn_double = 1'b0;
    repeat (22) tick();
    chk("bounce_once", int'(double_wash), 1);
    $display("seq bounce: dw=%0b", double_wash);

    // Acknowledge timeout exactly ACK_CYCLES after entering WAIT_ACK
    do_reset();
    btn_start = 1'b1;
    wait_start(seen);
    chk("tmo_start_seen", int'(seen), 1);
    repeat (8) tick();
    chk("tmo_busy_before", int'(busy), 1);
    chk("tmo_fault_before", int'(fault), 0);
    tick();
    chk("tmo_busy_after", int'(busy), 0);
    chk("tmo_fault_after", int'(fault), 1);
    btn_start = 1'b0;
    repeat (22) tick();
    $display("seq timeout: fault=%0b busy=%0b", fault, busy);

    // Full run with options selected, pause toggling and completion
    do_reset();
    press_apply(4'b0110, 1'b1);
    chk("run_sel_dw", int'(double_wash), 1);
    chk("run_sel_dry", int'(dry_wash), 1);
    run_start("run1");
    press_apply(4'b0100, 1'b0);
    chk("run_dry_frozen", int'(dry_wash), 1);
    press_apply(4'b1000, 1'b0);
    chk("run_pause1", int'(time_pause), 1);
    press_apply(4'b1000, 1'b0);
    chk("run_pause2", int'(time_pause), 0);
    press_apply(4'b1000, 1'b0);
    chk("run_pause3", int'(time_pause), 1);
    done = 1'b1;
    tick();
    chk("run_end_pause", int'(time_pause), 0);
    chk("run_end_busy", int'(busy), 0);
`ifdef WM_PANEL_AUTO_CLEAR_EN
    exp_dw_end = 0;
`else
    exp_dw_end = 1;
`endif
    tick();
    chk("run_end_dw", int'(double_wash), exp_dw_end);
    $display("seq run1: dw=%0b dry=%0b pause=%0b busy=%0b", double_wash, dry_wash, time_pause, busy);

    // Pause press landing in the same cycle as done=1 is discarded
    run_start("run2");
    btn_pause = 1'b1;
    repeat (18) tick();
    done = 1'b1;
    tick();
    chk("coinc_pause", int'(time_pause), 0);
    chk("coinc_busy", int'(busy), 0);
    btn_pause = 1'b0;
    repeat (22) tick();
    chk("coinc_pause_settled", int'(time_pause), 0);
    $display("seq run2: pause=%0b busy=%0b", time_pause, busy);

    // Reset mid-RUN clears outputs immediately; no spurious start afterwards
    run_start("run3");
    press_apply(4'b1000, 1'b0);
    chk("run3_pause", int'(time_pause), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", int'(start), 0);
    chk("mid_rst_double", int'(double_wash), 0);
    chk("mid_rst_dry", int'(dry_wash), 0);
    chk("mid_rst_pause", int'(time_pause), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_fault", int'(fault), 0);
    tick();
    rst_n = 1'b1;
    done = 1'b1;
    sc = start_cnt;
    repeat (40) tick();
    chk("post_rst_no_start", start_cnt - sc, 0);
    chk("post_rst_busy", int'(busy), 0);
    $display("seq reset: busy=%0b starts=%0d", busy, start_cnt - sc);

    chk("start_never_consecutive", consec_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
